// File: rtl/axi_stream_header_insert_strip_pkg.sv
// Shared constants, FSM state type and byte-enable helpers for the
// header insert/strip block and its byte-merge datapath.
package axis_hdr_pkg;

   localparam int DEF_DATA_WD      = 32;
   localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
   localparam int DEF_BYTE_CNT_WD  = $clog2(DEF_DATA_BYTE_WD);

   // Helpers work on a fixed wide keep vector; callers zero-extend/truncate.
   localparam int KEEP_MAX = 64;
   typedef logic [KEEP_MAX-1:0] keep_max_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   function automatic int keep_popcount(input keep_max_t k);
      int n;
      n = 0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         n += int'(k[i]);
      end
      return n;
   endfunction

   // cnt ones packed against bit w-1 (the first byte lane of a w-lane bus)
   function automatic keep_max_t cnt_to_keep_left(input int cnt, input int w);
      keep_max_t k;
      k = '0;
      for (int i = 0; i < KEEP_MAX; i++) begin
         if (i < w && i >= w - cnt) begin
            k[i] = 1'b1;
         end
      end
      return k;
   endfunction

   function automatic logic keep_is_left_contig(input keep_max_t k, input int w);
      return k == cnt_to_keep_left(keep_popcount(k), w);
   endfunction

   function automatic logic keep_is_right_contig(input keep_max_t k);
      keep_max_t m;
      int        n;
      m = '0;
      n = keep_popcount(k);
      for (int i = 0; i < KEEP_MAX; i++) begin
         if (i < n) begin
            m[i] = 1'b1;
         end
      end
      return k == m;
   endfunction

endpackage

// File: rtl/axi_stream_header_insert_strip_if.sv
// Payload-in, stream-out and command/header channels of the insert/strip block.
interface axi_stream_header_insert_strip_if
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = DEF_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
   logic                    valid_in;
   logic [DATA_WD-1:0]      data_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic                    last_in;
   logic                    ready_in;

   logic                    valid_out;
   logic [DATA_WD-1:0]      data_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic                    last_out;
   logic                    ready_out;

   logic                    valid_insert;
   logic [DATA_WD-1:0]      data_insert;
   logic [DATA_BYTE_WD-1:0] keep_insert;
   logic [BYTE_CNT_WD:0]    byte_insert_cnt;
   logic                    cmd_strip;
   logic                    ready_insert;

   logic                    err_keep;

   modport slave (
      input  valid_in, data_in, keep_in, last_in,
      output ready_in,
      output valid_out, data_out, keep_out, last_out,
      input  ready_out,
      input  valid_insert, data_insert, keep_insert, byte_insert_cnt, cmd_strip,
      output ready_insert,
      output err_keep
   );

   modport master (
      output valid_in, data_in, keep_in, last_in,
      input  ready_in,
      input  valid_out, data_out, keep_out, last_out,
      output ready_out,
      output valid_insert, data_insert, keep_insert, byte_insert_cnt, cmd_strip,
      input  ready_insert,
      input  err_keep
   );
endinterface

// File: rtl/axi_stream_header_insert_strip_byte_merge.sv
// Combinational 2W-byte window: residual bytes followed by the new beat,
// split into one emitted beat and the carried-over residual.
module axis_byte_merge
   import axis_hdr_pkg::*;
#(
   parameter int DATA_BYTE_WD = DEF_DATA_BYTE_WD,
   parameter int CNT_WD       = DEF_BYTE_CNT_WD + 1
) (
   input  logic [8*DATA_BYTE_WD-1:0] i_res_data,
   input  logic [CNT_WD-1:0]         i_res_cnt,
   input  logic [8*DATA_BYTE_WD-1:0] i_beat_data,
   input  logic [CNT_WD-1:0]         i_beat_cnt,
   output logic [8*DATA_BYTE_WD-1:0] o_emit_data,
   output logic [DATA_BYTE_WD-1:0]   o_emit_keep,
   output logic [8*DATA_BYTE_WD-1:0] o_res_data,
   output logic [CNT_WD-1:0]         o_res_cnt,
   output logic [CNT_WD:0]           o_total
);
   localparam int                W      = DATA_BYTE_WD;
   localparam int                DW     = 8 * W;
   localparam int                TOT_WD = CNT_WD + 1;
   localparam logic [CNT_WD:0]   W_TOT  = TOT_WD'(W);
   localparam logic [CNT_WD-1:0] W_CNT  = CNT_WD'(W);

   logic [W-1:0]      w_beat_keep;
   logic [DW-1:0]     w_beat_masked;
   logic [2*DW-1:0]   w_window;
   logic [CNT_WD:0]   w_total;
   logic              w_full;
   logic [CNT_WD-1:0] w_emit_cnt;

   assign w_beat_keep = W'(cnt_to_keep_left(int'(i_beat_cnt), W));

   // Lanes past the beat's byte count are zeroed so they cannot pollute the OR below.
   for (genvar gi = 0; gi < W; gi++) begin : g_beat_mask
      assign w_beat_masked[8*gi +: 8] = w_beat_keep[gi] ? i_beat_data[8*gi +: 8] : 8'h00;
   end

   assign w_window   = {i_res_data, {DW{1'b0}}}
                     | ({w_beat_masked, {DW{1'b0}}} >> {i_res_cnt, 3'b000});
   assign w_total    = {1'b0, i_res_cnt} + {1'b0, i_beat_cnt};
   assign w_full     = (w_total >= W_TOT);
   assign w_emit_cnt = w_full ? W_CNT : w_total[CNT_WD-1:0];

   assign o_emit_data = w_window[2*DW-1 -: DW];
   assign o_emit_keep = W'(cnt_to_keep_left(int'(w_emit_cnt), W));
   assign o_res_data  = w_full ? w_window[DW-1:0] : w_window[2*DW-1 -: DW];
   assign o_res_cnt   = w_full ? CNT_WD'(w_total - W_TOT) : w_total[CNT_WD-1:0];
   assign o_total     = w_total;

endmodule

// File: rtl/axi_stream_header_insert_strip.sv
// Per-packet header insert or leading-byte strip on a byte-packed AXI-Stream,
// with registered output and full backpressure.
module axi_stream_header_insert_strip
   import axis_hdr_pkg::*;
#(
   parameter int DATA_WD      = DEF_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input logic clk,
   input logic rst,
   axi_stream_header_insert_strip_if.slave bus
);
   localparam int                W      = DATA_BYTE_WD;
   localparam int                CNT_WD = BYTE_CNT_WD + 1;
   localparam int                TOT_WD = CNT_WD + 1;
   localparam logic [CNT_WD-1:0] W_CNT  = CNT_WD'(W);
   localparam logic [CNT_WD:0]   W_TOT  = TOT_WD'(W);
   localparam logic [W-1:0]      KEEP_ALL = '1;

   logic [1:0]          r_rst_sync;
   logic                w_rst;

   state_t              r_state, w_state_next;
   logic [DATA_WD-1:0]  r_res_data, w_res_data_next;
   logic [CNT_WD-1:0]   r_res_cnt, w_res_cnt_next;
   logic                r_strip, w_strip_next;
   logic                r_first, w_first_next;
   logic [CNT_WD-1:0]   r_drop, w_drop_next;
   logic                r_valid_out, w_valid_out_next;
   logic [DATA_WD-1:0]  r_data_out, w_data_out_next;
   logic [W-1:0]        r_keep_out, w_keep_out_next;
   logic                r_last_out, w_last_out_next;
   logic                r_err_keep, w_err_keep_next;

   logic                w_ready_in, w_ready_insert, w_cmd_fire, w_beat_fire, w_out_free;
   logic [CNT_WD-1:0]   w_cmd_cnt, w_keep_in_cnt, w_drop_eff, w_beat_cnt;
   logic [DATA_WD-1:0]  w_hdr_data, w_beat_data;
   logic                w_cmd_err, w_beat_err;
   logic [W-1:0]        w_flush_keep;
   logic [DATA_WD-1:0]  w_m_emit_data, w_m_res_data;
   logic [W-1:0]        w_m_emit_keep;
   logic [CNT_WD-1:0]   w_m_res_cnt;
   logic [CNT_WD:0]     w_m_total;

   // Reset asserts immediately but leaves the block two clocks after rst falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rst_sync <= 2'b11;
      else     r_rst_sync <= {r_rst_sync[0], 1'b0};
   end
   assign w_rst = r_rst_sync[1];

   assign w_out_free     = !r_valid_out || bus.ready_out;
   assign w_ready_insert = (r_state == IDLE) && !w_rst;
   assign w_ready_in     = (r_state == STREAM) && w_out_free;
   assign w_cmd_fire     = bus.valid_insert && w_ready_insert;
   assign w_beat_fire    = bus.valid_in && w_ready_in;

   assign w_cmd_cnt  = (bus.byte_insert_cnt > W_CNT) ? W_CNT : bus.byte_insert_cnt;
   assign w_hdr_data = bus.data_insert << (8 * (W - int'(w_cmd_cnt)));

   // Strip drops leading bytes of the first payload beat only.
   assign w_keep_in_cnt = CNT_WD'(keep_popcount(KEEP_MAX'(bus.keep_in)));
   assign w_drop_eff    = (r_strip && r_first) ? r_drop : '0;
   assign w_beat_data   = bus.data_in << {w_drop_eff, 3'b000};
   assign w_beat_cnt    = (w_keep_in_cnt > w_drop_eff) ? (w_keep_in_cnt - w_drop_eff) : '0;

   assign w_cmd_err  = bus.cmd_strip
                     ? (bus.byte_insert_cnt >= W_CNT)
                     : (!keep_is_right_contig(KEEP_MAX'(bus.keep_insert))
                        || keep_popcount(KEEP_MAX'(bus.keep_insert)) != int'(bus.byte_insert_cnt));
   assign w_beat_err = bus.last_in
                     ? (!keep_is_left_contig(KEEP_MAX'(bus.keep_in), W) || bus.keep_in == '0)
                     : (bus.keep_in != KEEP_ALL);

   assign w_flush_keep = W'(cnt_to_keep_left(int'(r_res_cnt), W));

   axis_byte_merge #(
      .DATA_BYTE_WD (W),
      .CNT_WD       (CNT_WD)
   ) u_merge (
      .i_res_data  (r_res_data),
      .i_res_cnt   (r_res_cnt),
      .i_beat_data (w_beat_data),
      .i_beat_cnt  (w_beat_cnt),
      .o_emit_data (w_m_emit_data),
      .o_emit_keep (w_m_emit_keep),
      .o_res_data  (w_m_res_data),
      .o_res_cnt   (w_m_res_cnt),
      .o_total     (w_m_total)
   );

   always_comb begin
      w_state_next     = r_state;
      w_res_data_next  = r_res_data;
      w_res_cnt_next   = r_res_cnt;
      w_strip_next     = r_strip;
      w_first_next     = r_first;
      w_drop_next      = r_drop;
      w_valid_out_next = r_valid_out;
      w_data_out_next  = r_data_out;
      w_keep_out_next  = r_keep_out;
      w_last_out_next  = r_last_out;
      w_err_keep_next  = 1'b0;
      if (bus.ready_out) w_valid_out_next = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_cmd_fire) begin
               w_state_next    = STREAM;
               w_first_next    = 1'b1;
               w_strip_next    = bus.cmd_strip;
               w_err_keep_next = w_cmd_err;
               if (bus.cmd_strip) begin
                  w_res_data_next = '0;
                  w_res_cnt_next  = '0;
                  w_drop_next     = w_cmd_cnt;
               end else begin
                  w_res_data_next = w_hdr_data;
                  w_res_cnt_next  = w_cmd_cnt;
                  w_drop_next     = '0;
               end
            end
         end
         STREAM: begin
            if (w_beat_fire) begin
               w_first_next    = 1'b0;
               w_err_keep_next = w_beat_err;
               w_res_data_next = w_m_res_data;
               w_res_cnt_next  = w_m_res_cnt;
               if (bus.last_in || w_m_total >= W_TOT) begin
                  w_valid_out_next = 1'b1;
                  w_data_out_next  = w_m_emit_data;
                  w_keep_out_next  = w_m_emit_keep;
                  w_last_out_next  = 1'b0;
               end
               // A last beat that overflows one output beat leaves a FLUSH beat behind.
               if (bus.last_in && w_m_total <= W_TOT) begin
                  w_last_out_next = 1'b1;
                  w_state_next    = IDLE;
                  w_res_data_next = '0;
                  w_res_cnt_next  = '0;
               end else if (bus.last_in) begin
                  w_state_next = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (w_out_free) begin
               w_valid_out_next = 1'b1;
               w_data_out_next  = r_res_data;
               w_keep_out_next  = w_flush_keep;
               w_last_out_next  = 1'b1;
               w_state_next     = IDLE;
               w_res_data_next  = '0;
               w_res_cnt_next   = '0;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         r_state     <= IDLE;
         r_res_data  <= '0;
         r_res_cnt   <= '0;
         r_strip     <= 1'b0;
         r_first     <= 1'b0;
         r_drop      <= '0;
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
         r_keep_out  <= '0;
         r_last_out  <= 1'b0;
         r_err_keep  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_res_data  <= w_res_data_next;
         r_res_cnt   <= w_res_cnt_next;
         r_strip     <= w_strip_next;
         r_first     <= w_first_next;
         r_drop      <= w_drop_next;
         r_valid_out <= w_valid_out_next;
         r_data_out  <= w_data_out_next;
         r_keep_out  <= w_keep_out_next;
         r_last_out  <= w_last_out_next;
         r_err_keep  <= w_err_keep_next;
      end
   end

   assign bus.ready_in     = w_ready_in;
   assign bus.ready_insert = w_ready_insert;
   assign bus.valid_out    = r_valid_out;
   assign bus.data_out     = r_data_out;
   assign bus.keep_out     = r_keep_out;
   assign bus.last_out     = r_last_out;
   assign bus.err_keep     = r_err_keep;

endmodule

// File: tb/tb_axi_stream_header_insert_strip.sv
// Scoreboard bench for the header insert/strip block at W=4.
module tb_axi_stream_header_insert_strip;
   import axis_hdr_pkg::*;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   axi_stream_header_insert_strip_if #(.DATA_WD(32)) bus ();

   axi_stream_header_insert_strip #(.DATA_WD(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Output monitor: every handshaken beat is popped from the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected got data=%h keep=%b last=%0d required no beat",
                     bus.data_out, bus.keep_out, bus.last_out);
         end else begin
            e = exp_q.pop_front();
            if ({bus.data_out, bus.keep_out, bus.last_out} !== {e.d, e.k, e.l}) begin
               n_fail++;
               $display("FAIL out_beat got data=%h keep=%b last=%0d required data=%h keep=%b last=%0d",
                        bus.data_out, bus.keep_out, bus.last_out, e.d, e.k, e.l);
            end else begin
               $display("out beat data=%h keep=%b last=%0d", bus.data_out, bus.keep_out, bus.last_out);
            end
         end
      end
   end

   task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t e;
      e.d = d; e.k = k; e.l = l;
      exp_q.push_back(e);
   endtask

   task automatic send_cmd(input logic strip, input logic [31:0] d, input logic [3:0] k,
                           input logic [2:0] cnt);
      bit done = 0;
      bus.valid_insert = 1'b1; bus.cmd_strip = strip; bus.data_insert = d;
      bus.keep_insert = k; bus.byte_insert_cnt = cnt;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.ready_insert === 1'b1) done = 1;
         @(posedge clk); #1;
      end
      bus.valid_insert = 1'b0;
      $display("cmd strip=%0d data=%h keep=%b cnt=%0d", strip, d, k, cnt);
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL cmd_handshake got no ready_insert required accept within 200 cycles");
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit done = 0;
      bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.ready_in === 1'b1) done = 1;
         @(posedge clk); #1;
      end
      bus.valid_in = 1'b0;
      $display("in beat data=%h keep=%b last=%0d", d, k, l);
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL beat_handshake got no ready_in required accept within 200 cycles");
      end
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3 rst = 1'b1;
      #1;
      n_checks++; if (bus.valid_out !== 1'b0)    begin n_fail++; $display("FAIL rst_valid_out got %b required 0", bus.valid_out); end
      n_checks++; if (bus.last_out !== 1'b0)     begin n_fail++; $display("FAIL rst_last_out got %b required 0", bus.last_out); end
      n_checks++; if (bus.err_keep !== 1'b0)     begin n_fail++; $display("FAIL rst_err_keep got %b required 0", bus.err_keep); end
      n_checks++; if (bus.ready_in !== 1'b0)     begin n_fail++; $display("FAIL rst_ready_in got %b required 0", bus.ready_in); end
      n_checks++; if (bus.ready_insert !== 1'b0) begin n_fail++; $display("FAIL rst_ready_insert got %b required 0", bus.ready_insert); end
      n_checks++; if (bus.data_out !== 32'h0)    begin n_fail++; $display("FAIL rst_data_out got %h required 0", bus.data_out); end
      n_checks++; if (bus.keep_out !== 4'h0)     begin n_fail++; $display("FAIL rst_keep_out got %b required 0", bus.keep_out); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.ready_insert !== 1'b1) begin n_fail++; $display("FAIL idle_ready_insert got %b required 1", bus.ready_insert); end
      @(posedge clk); #1;
   endtask

   task automatic test_insert_two_beats();
      push_exp(32'hCCDD1122, 4'hF, 1'b0);
      push_exp(32'h33445566, 4'hF, 1'b1);
      send_cmd(1'b0, 32'hAABBCCDD, 4'b0011, 3'd2);
      send_beat(32'h11223344, 4'hF, 1'b0);
      send_beat(32'h55667788, 4'b1100, 1'b1);
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL insert_drain got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_insert_flush();
      push_exp(32'hAABBCC11, 4'hF, 1'b0);
      push_exp(32'h22330000, 4'b1100, 1'b1);
      send_cmd(1'b0, 32'h00AABBCC, 4'b0111, 3'd3);
      send_beat(32'h11223344, 4'b1110, 1'b1);
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL flush_drain got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_strip();
      push_exp(32'h22334455, 4'hF, 1'b1);
      send_cmd(1'b1, 32'h0, 4'h0, 3'd1);
      send_beat(32'h11223344, 4'hF, 1'b0);
      send_beat(32'h55667788, 4'b1000, 1'b1);
      push_exp(32'h00000000, 4'h0, 1'b1);
      send_cmd(1'b1, 32'h0, 4'h0, 3'd2);
      send_beat(32'h11223344, 4'b1100, 1'b1);
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL strip_drain got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      push_exp(32'hCCDD1122, 4'hF, 1'b0);
      push_exp(32'h33445566, 4'hF, 1'b1);
      bus.ready_out = 1'b0;
      send_cmd(1'b0, 32'hAABBCCDD, 4'b0011, 3'd2);
      send_beat(32'h11223344, 4'hF, 1'b0);
      fork
         send_beat(32'h55667788, 4'b1100, 1'b1);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               n_checks++;
               if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hCCDD1122) begin
                  n_fail++;
                  $display("FAIL bp_hold got valid=%b data=%h required valid=1 data=ccdd1122", bus.valid_out, bus.data_out);
               end
               n_checks++;
               if (bus.ready_in !== 1'b0) begin
                  n_fail++;
                  $display("FAIL bp_ready_in got %b required 0", bus.ready_in);
               end
            end
            @(posedge clk); #1;
            bus.ready_out = 1'b1;
         end
      join
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_edge_counts();
      push_exp(32'hA1A2A3A4, 4'hF, 1'b0);
      push_exp(32'hB1B2B300, 4'b1110, 1'b1);
      send_cmd(1'b0, 32'h12345678, 4'b0000, 3'd0);
      send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
      send_beat(32'hB1B2B300, 4'b1110, 1'b1);
      push_exp(32'hDEADBEEF, 4'hF, 1'b0);
      push_exp(32'h01020304, 4'hF, 1'b0);
      push_exp(32'h05060708, 4'hF, 1'b1);
      send_cmd(1'b0, 32'hDEADBEEF, 4'b1111, 3'd4);
      send_beat(32'h01020304, 4'hF, 1'b0);
      send_beat(32'h05060708, 4'hF, 1'b1);
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL edge_drain got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_packet();
      bus.ready_out = 1'b0;
      send_cmd(1'b0, 32'hAABBCCDD, 4'b0011, 3'd2);
      send_beat(32'h11223344, 4'hF, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b required 1", bus.valid_out); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b required 0", bus.valid_out); end
      n_checks++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got %h required 0", bus.data_out); end
      n_checks++; if (bus.keep_out !== 4'h0)  begin n_fail++; $display("FAIL mid_rst_keep got %b required 0", bus.keep_out); end
      n_checks++; if (bus.last_out !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_last got %b required 0", bus.last_out); end
      exp_q.delete();
      bus.ready_out = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      test_insert_flush();
   endtask

   task automatic test_err_keep();
      push_exp(32'hCCDD1122, 4'hF, 1'b1);
      send_cmd(1'b0, 32'hAABBCCDD, 4'b0011, 3'd2);
      n_checks++; if (bus.err_keep !== 1'b0) begin n_fail++; $display("FAIL err_legal_cmd got %b required 0", bus.err_keep); end
      send_beat(32'h11223344, 4'b1010, 1'b1);
      n_checks++; if (bus.err_keep !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b required 1", bus.err_keep); end
      @(posedge clk); #1;
      n_checks++; if (bus.err_keep !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle got %b required 0", bus.err_keep); end
      wait_drain();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL err_drain got %0d pending required 0", exp_q.size()); end
   endtask

   initial begin
      bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
      bus.ready_out = 1'b1;
      bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0;
      bus.byte_insert_cnt = '0; bus.cmd_strip = 1'b0;
      test_reset();
      test_insert_two_beats();
      test_insert_flush();
      test_strip();
      test_backpressure();
      test_edge_counts();
      test_reset_mid_packet();
      test_err_keep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_stream_header_insert_strip.md
Name: axi_stream_header_insert_strip

Overview:
Parametrised successor to the header-insert block. Per packet, one command on the insert channel selects one of two operations, both using the same byte-repacking datapath. Insert mode prepends 0..DATA_BYTE_WD header bytes to an AXI-Stream payload. Strip mode removes 0..DATA_BYTE_WD-1 leading payload bytes. Output is registered, honours full backpressure, and always leaves the block byte-packed: full beats, with a left-aligned keep on the last beat.

Parameters:
DATA_WD, 32, data bus width in bits; multiple of 8, at least 16
DATA_BYTE_WD, DATA_WD/8, bytes per beat (W)
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width; count ports are BYTE_CNT_WD+1 bits wide

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  payload valid
data_in  in  DATA_WD  payload; byte order MSB first (data[DATA_WD-1 -: 8] is first byte)
keep_in  in  DATA_BYTE_WD  byte enables; keep[W-1] is the first byte
last_in  in  1  last payload beat
ready_in  out  1  payload ready
valid_out  out  1  output valid
data_out  out  DATA_WD  output data
keep_out  out  DATA_BYTE_WD  output byte enables
last_out  out  1  output last
ready_out  in  1  downstream ready
valid_insert  in  1  command/header valid
data_insert  in  DATA_WD  header bytes, right-aligned
keep_insert  in  DATA_BYTE_WD  header byte enables, right-aligned contiguous
byte_insert_cnt  in  BYTE_CNT_WD+1  header byte count h (insert mode) or strip count s (strip mode)
cmd_strip  in  1  0 = insert, 1 = strip; data_insert/keep_insert ignored when 1
ready_insert  out  1  command ready
err_keep  out  1  one-cycle pulse on an illegal keep value

Behaviour:
- Reset (rst high, async):
  - state=IDLE; residual cleared.
  - valid_out, last_out, err_keep, ready_in, ready_insert = 0; data_out, keep_out = 0.
  - rst is released synchronously inside the block.
- States:
  - IDLE: ready_insert=1, ready_in=0. Command handshake goes to STREAM.
    - Insert: residual loaded with h header bytes, r=h (0..W).
    - Strip: r=0, drop=s.
  - STREAM: ready_insert=0; ready_in = !flush_pend && (!valid_out || ready_out).
  - FLUSH: ready_in=0. Emits the remaining residual when the output register is free, then returns to IDLE.
- Per accepted payload beat:
  - n = popcount(keep_in). First beat in strip mode uses n-s bytes, with the leading s bytes dropped.
  - t = r + n; combined byte stream = residual followed by new bytes.
  - t >= W: emit the first W bytes with keep all-ones; r' = t-W (r never exceeds W).
  - t < W and not last: no emission; r' = t.
  - last and t <= W: emit t bytes with last_out=1; next state IDLE.
  - last and t > W: emit W bytes with last_out=0, then a FLUSH beat of t-W bytes with last_out=1.
- Output encoding:
  - keep_out is left-aligned contiguous; invalid byte lanes are driven 0.
  - Null result (strip leaves 0 bytes): one beat with keep_out=0, last_out=1.
- Latency: an output beat is valid the cycle after the input beat that completes it.
- Output stability: while valid_out && !ready_out, data_out/keep_out/last_out are held stable and ready_in=0.
- valid_in while in IDLE is not accepted. The next command is accepted no earlier than the cycle after the packet's final output beat is loaded.
- Input keep rules:
  - Non-last beats: keep_in must be all-ones.
  - Last beat: left-aligned contiguous, nonzero.
  - keep_insert: right-aligned, popcount == h.
  - s <= W-1.
  - Any violation pulses err_keep; data is processed using byte_insert_cnt/popcount.
- Reset mid-packet: all state is discarded; the partial packet is not completed.

Decomposition:
- Package axis_hdr_pkg holds:
  - W/count-width constants and the state enum (IDLE, STREAM, FLUSH).
  - Functions keep_popcount, cnt_to_keep_left, keep_is_left_contig, keep_is_right_contig.
- Sub-module axis_byte_merge: purely combinational residual+beat concatenation and left shift (2W-byte window). Outputs are emit data/keep, the new residual and the new count.
- The top level holds the FSM, residual register and output register.

Test Plan (W=4):
1. Insert, header 0xAABBCCDD keep 0011 h=2; payload 0x11223344 F, then 0x55667788 last keep 1100 -> 0xCCDD1122 keep F, then 0x33445566 keep F last.
2. Insert, header 0x00AABBCC keep 0111 h=3; payload single beat 0x11223344 last keep 1110 -> 0xAABBCC11 keep F, then FLUSH beat 0x22330000 keep 1100 last.
3. Strip s=1; payload 0x11223344 F, then 0x55667788 last keep 1000 -> single beat 0x22334455 keep F last. Strip s=2, single beat keep 1100 last -> one beat keep 0000 last.
4. Case 1 with ready_out low for 8 cycles after the first output -> data_out held at 0xCCDD1122; ready_in=0 throughout; same two beats delivered, no duplicates.
5. h=0 (keep_insert 0000) -> payload passes unchanged. h=4 header 0xDEADBEEF -> header emitted as its own full beat, then payload beats unchanged.
6. rst pulsed mid-payload of case 1 -> all outputs 0 immediately. Case 2 then completes correctly. keep_in=1010 on a last beat pulses err_keep.
